// File: rtl/panel_run_controller.sv
// Front-panel run controller: turns debounced button presses into single-step,
// free-run, halt and timed processor-reset actions with latched event LEDs.
module panel_run_controller #(
  parameter int RUN_DIV    = 50000000,
  parameter int RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_lvl,
  output logic       cpu_ce,
  output logic       cpu_rst,
  output logic [1:0] state,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RSTHOLD = 2'd2
  } state_t;

  localparam logic [25:0] DIV_LAST  = 26'(RUN_DIV - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  prev_q, prev_d;
  logic [3:0]  pending_q, pending_d;
  logic [25:0] div_q, div_d;
  logic [7:0]  hold_q, hold_d;
  logic        cpu_ce_q, cpu_ce_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [3:0]  rise;
  logic [3:0]  grant;

  always_comb begin
    rise  = btn_lvl & ~prev_q;
    grant = 4'b0000;
    if (state_q != ST_RSTHOLD) begin
      if (pending_q[3])      grant = 4'b1000;
      else if (pending_q[2]) grant = 4'b0100;
      else if (pending_q[1]) grant = 4'b0010;
      else if (pending_q[0]) grant = 4'b0001;
    end

    prev_d    = btn_lvl;
    pending_d = (pending_q & ~grant) | rise;
    state_d   = state_q;
    div_d     = div_q;
    hold_d    = hold_q;
    cpu_ce_d  = 1'b0;
    cpu_rst_d = 1'b0;

    // A cpu-reset grant preempts everything and discards edges seen this cycle
    if (grant[3]) begin
      state_d   = ST_RSTHOLD;
      pending_d = 4'b0000;
      div_d     = '0;
      hold_d    = '0;
      cpu_rst_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant[0]) begin
            cpu_ce_d = 1'b1;
          end else if (grant[1]) begin
            state_d = ST_RUN;
            div_d   = '0;
          end
        end
        ST_RUN: begin
          if (grant[2]) begin
            state_d = ST_IDLE;
            div_d   = '0;
          end else if (div_q == DIV_LAST) begin
            div_d    = '0;
            cpu_ce_d = 1'b1;
          end else begin
            div_d = div_q + 26'd1;
          end
        end
        ST_RSTHOLD: begin
          pending_d = 4'b0000;
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d    = hold_q + 8'd1;
            cpu_rst_d = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          pending_d = 4'b0000;
          div_d     = '0;
          hold_d    = '0;
        end
      endcase
    end
  end

  // prev resets to all-ones so a button held through reset is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      prev_q    <= 4'b1111;
      pending_q <= 4'b0000;
      div_q     <= '0;
      hold_q    <= '0;
      cpu_ce_q  <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      div_q     <= div_d;
      hold_q    <= hold_d;
      cpu_ce_q  <= cpu_ce_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign cpu_ce  = cpu_ce_q;
  assign cpu_rst = cpu_rst_q;
  assign state   = state_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_panel_run_controller.sv
// Self-checking bench for panel_run_controller: directed scenarios followed by
// random button traffic, all compared every cycle against an event-level model.
module tb_panel_run_controller;

  localparam int RUN_DIV    = 4;
  localparam int RST_CYCLES = 3;

  logic       clk;
  logic       reset;
  logic [3:0] btn_lvl;
  logic       cpu_ce;
  logic       cpu_rst;
  logic [1:0] state;
  logic [3:0] pending;

  int total;
  int bad;
  int ce_cnt;
  int rst_cnt;

  // Reference model: mode 0=IDLE 1=RUN 2=RSTHOLD, times measured in clock edges
  int         m_n;
  int         m_mode;
  int         m_run_start;
  int         m_hold_until;
  logic [3:0] m_prev;
  logic [3:0] m_pend;
  logic       m_ce;
  logic       m_rst;

  panel_run_controller #(
    .RUN_DIV   (RUN_DIV),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_lvl(btn_lvl),
    .cpu_ce (cpu_ce),
    .cpu_rst(cpu_rst),
    .state  (state),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n          = 0;
    m_mode       = 0;
    m_run_start  = 0;
    m_hold_until = 0;
    m_prev       = 4'b1111;
    m_pend       = 4'b0000;
    m_ce         = 1'b0;
    m_rst        = 1'b0;
  endtask

  // Advance the model by one clock edge with button levels b sampled
  task automatic model_edge(input logic [3:0] b);
    logic [3:0] rise;
    int g;
    rise   = b & ~m_prev;
    m_prev = b;
    m_n++;
    m_ce = 1'b0;
    if (m_mode == 2) begin
      m_pend = 4'b0000;
      if (m_n == m_hold_until) begin
        m_mode = 0;
        m_rst  = 1'b0;
      end
    end else begin
      g = -1;
      for (int i = 3; i >= 0; i--) if (g < 0 && m_pend[i]) g = i;
      if (g >= 0) m_pend[g] = 1'b0;
      m_pend = m_pend | rise;
      if (g == 3) begin
        m_mode       = 2;
        m_pend       = 4'b0000;
        m_rst        = 1'b1;
        m_hold_until = m_n + RST_CYCLES;
      end else if (m_mode == 0) begin
        if (g == 0) m_ce = 1'b1;
        else if (g == 1) begin
          m_mode      = 1;
          m_run_start = m_n;
        end
      end else begin
        if (g == 2) m_mode = 0;
        else if (((m_n - m_run_start) % RUN_DIV) == 0) m_ce = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    chk("cpu_ce", {31'b0, cpu_ce}, {31'b0, m_ce});
    chk("cpu_rst", {31'b0, cpu_rst}, {31'b0, m_rst});
    chk("state", {30'b0, state}, m_mode);
    chk("pending", {28'b0, pending}, {28'b0, m_pend});
    chk("ce_rst_exclusive", {31'b0, cpu_ce & cpu_rst}, 32'd0);
  endtask

  task automatic applyStimulus(input logic [3:0] b);
    btn_lvl = b;
    @(posedge clk);
    model_edge(b);
    #1;
    checkOutput();
    if (cpu_ce === 1'b1) ce_cnt++;
    if (cpu_rst === 1'b1) rst_cnt++;
  endtask

  // Assert reset away from a clock edge, confirm the asynchronous clear, release
  task automatic reset_dut();
    reset = 1'b0;
    #1;
    chk("rst_async_ce", {31'b0, cpu_ce}, 32'd0);
    chk("rst_async_rst", {31'b0, cpu_rst}, 32'd0);
    chk("rst_async_state", {30'b0, state}, 32'd0);
    chk("rst_async_pending", {28'b0, pending}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] rb;
    total   = 0;
    bad     = 0;
    ce_cnt  = 0;
    rst_cnt = 0;
    btn_lvl = 4'b0000;
    reset   = 1'b0;
    model_reset();

    // Power-on reset state
    repeat (3) @(posedge clk);
    #1;
    chk("por_state", {30'b0, state}, 32'd0);
    chk("por_ce", {31'b0, cpu_ce}, 32'd0);
    chk("por_rst", {31'b0, cpu_rst}, 32'd0);
    chk("por_pending", {28'b0, pending}, 32'd0);
    reset = 1'b1;

    // Single step: one pulse, stays IDLE
    ce_cnt = 0;
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    applyStimulus(4'b0001);
    repeat (5) applyStimulus(4'b0000);
    chk("step_pulse_count", ce_cnt, 32'd1);
    chk("step_state", {30'b0, state}, 32'd0);

    // Free run held 20 cycles, then halt lands on a scheduled pulse
    ce_cnt = 0;
    repeat (20) applyStimulus(4'b0010);
    chk("run_pulse_count", ce_cnt, 32'd4);
    chk("run_state", {30'b0, state}, 32'd1);
    ce_cnt = 0;
    applyStimulus(4'b0100);
    repeat (12) applyStimulus(4'b0000);
    chk("halt_no_pulse", ce_cnt, 32'd0);
    chk("halt_state", {30'b0, state}, 32'd0);

    // cpu-reset from RUN
    applyStimulus(4'b0010);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    ce_cnt  = 0;
    rst_cnt = 0;
    applyStimulus(4'b1000);
    repeat (8) applyStimulus(4'b0000);
    chk("rsthold_rst_cycles", rst_cnt, RST_CYCLES);
    chk("rsthold_no_ce", ce_cnt, 32'd0);
    chk("rsthold_exit_state", {30'b0, state}, 32'd0);
    chk("rsthold_exit_pending", {28'b0, pending}, 32'd0);

    // Simultaneous step and run: run wins, step swallowed in RUN
    ce_cnt = 0;
    applyStimulus(4'b0011);
    repeat (4) applyStimulus(4'b0000);
    chk("steprun_no_ce", ce_cnt, 32'd0);
    chk("steprun_state", {30'b0, state}, 32'd1);
    applyStimulus(4'b0100);
    repeat (3) applyStimulus(4'b0000);

    // Step held through reset release gives no event until re-pressed
    btn_lvl = 4'b0001;
    reset_dut();
    ce_cnt = 0;
    repeat (5) applyStimulus(4'b0001);
    chk("held_no_ce", ce_cnt, 32'd0);
    ce_cnt = 0;
    applyStimulus(4'b0000);
    applyStimulus(4'b0001);
    repeat (4) applyStimulus(4'b0000);
    chk("repress_one_ce", ce_cnt, 32'd1);

    // Reset pulsed in the middle of RSTHOLD
    applyStimulus(4'b1000);
    applyStimulus(4'b0000);
    chk("mid_hold_rst_high", {31'b0, cpu_rst}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_hold_rst_drop", {31'b0, cpu_rst}, 32'd0);
    chk("mid_hold_state", {30'b0, state}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    applyStimulus(4'b0000);
    chk("after_abort_state", {30'b0, state}, 32'd0);

    // Random button traffic against the model
    rb = 4'b0000;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
      end
      if (rb[3] && $urandom_range(0, 3) != 0) rb[3] = 1'b0;
      applyStimulus(rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/panel_run_controller.md
PANEL_RUN_CONTROLLER -- requirements
Module: panel_run_controller

Interface
REQ-001 SHALL have parameter RUN_DIV, default 50000000, giving the clk cycles per cpu_ce pulse in RUN, legal range 2..2^26.
REQ-002 SHALL have parameter RST_CYCLES, default 16, giving the cpu_rst assertion length in clk cycles, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port btn_lvl, input, 4 bits, already-debounced button levels: [0] step, [1] run, [2] halt, [3] cpu-reset.
REQ-006 SHALL have port cpu_ce, output, 1 bit, registered processor clock-enable pulse.
REQ-007 SHALL have port cpu_rst, output, 1 bit, registered active-high processor reset.
REQ-008 SHALL have port state, output, 2 bits, current FSM state: IDLE=0, RUN=1, RSTHOLD=2; value 3 unused.
REQ-009 SHALL have port pending, output, 4 bits, latched unserviced button events (LED drive).

Function
REQ-010 SHALL register btn_lvl into prev[3:0] every cycle and detect rising edges as btn_lvl & ~prev.
REQ-011 A rising edge on bit i SHALL set pending[i] on the next clk edge.
REQ-012 If a set and a grant-clear of the same bit occur in one cycle, the set SHALL win.
REQ-013 Arbitration SHALL be fixed priority, 3 > 2 > 1 > 0, granting at most one pending bit per cycle; the grant SHALL clear that bit.
REQ-014 Grants SHALL occur only in IDLE or RUN; in RSTHOLD no grant occurs.
REQ-015 IDLE, grant step: cpu_ce SHALL be 1 for exactly the next cycle; state stays IDLE.
REQ-016 IDLE, grant run: SHALL go to RUN and clear div counter to 0.
REQ-017 IDLE, grant halt: SHALL consume the event with no other effect.
REQ-018 RUN: div counter SHALL increment each cycle; at RUN_DIV-1 it SHALL wrap to 0 and cpu_ce SHALL be 1 for the following cycle. First pulse comes RUN_DIV cycles after entry; period is exactly RUN_DIV.
REQ-019 RUN, grant halt: SHALL go to IDLE next cycle, clear the counter, and emit no further cpu_ce (a pulse already scheduled for that cycle is suppressed).
REQ-020 RUN, grant step or run: SHALL consume the event and ignore it; the counter is undisturbed.
REQ-021 Grant cpu-reset from IDLE or RUN: SHALL go to RSTHOLD, clear pending[3:0] and the div counter, and drive cpu_rst=1 and cpu_ce=0 for exactly RST_CYCLES cycles, then go to IDLE with cpu_rst=0.
REQ-022 Rising edges during RSTHOLD SHALL be discarded; pending stays 0 until IDLE is re-entered.
REQ-023 Hold counter SHALL be 8 bits and div counter 26 bits; neither SHALL overflow within legal parameter ranges.
REQ-024 Outside the cases above, cpu_ce SHALL be 0; cpu_ce and cpu_rst SHALL never both be 1.

Reset
REQ-025 Asserting reset low SHALL immediately force state=IDLE, cpu_ce=0, cpu_rst=0, pending=0, both counters 0, and prev=4'b1111.
REQ-026 A button held through reset release SHALL produce no event until it is released and pressed again.
REQ-027 Reset asserted mid-RUN or mid-RSTHOLD SHALL abort the operation with no glitch on cpu_ce; cpu_rst SHALL drop asynchronously.

Verification
REQ-028 RUN_DIV=4; reset release, pulse btn_lvl[0] -> exactly one cpu_ce pulse, 2 cycles after the edge is sampled; state=0.
REQ-029 RUN_DIV=4; press run, hold 20 cycles -> state=1; cpu_ce pulses every 4th cycle, first pulse 4 cycles after RUN entry; press halt -> state=0 with no cpu_ce afterwards.
REQ-030 RST_CYCLES=3; in RUN, press cpu-reset -> cpu_rst=1 for exactly 3 cycles, cpu_ce=0 throughout, then state=0 and pending=0.
REQ-031 Step and run edges in the same cycle from IDLE -> run granted first (state=1), then step consumed with no extra cpu_ce.
REQ-032 btn_lvl=4'b0001 held across reset release -> no cpu_ce; release and re-press -> one cpu_ce.
REQ-033 Reset pulsed low mid-RSTHOLD -> cpu_rst=0 immediately; after release, state=0.
